// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Back-pressure is registered: in_ready depends only on skid occupancy, hold and clear.
module pipe_skid_reg #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   count
);

    logic         main_valid_q, main_valid_d;
    logic [N-1:0] main_data_q,  main_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [N-1:0] skid_data_q,  skid_data_d;
    logic         in_fire;
    logic         out_fire;

    assign in_ready  = rst_n & ~skid_valid_q & ~hold & ~clear;
    assign out_valid = main_valid_q & ~hold;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_data_q;
    assign count     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (hold) begin
            main_valid_d = main_valid_q;
        end else if (clear) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end else if (!main_valid_q) begin
            if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end else if (out_fire) begin
            // Skid entry is older than any incoming word, so it drains first.
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule
